// File: rtl/branch_predictor_param_pkg.sv
// Shared constants and helpers for the fetch-stage branch predictor.
// Counter encodings, indexing modes and the saturating counter update.
package bp_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam int MODE_BIMODAL = 0;
  localparam int MODE_GSHARE  = 1;

  // Two-bit saturating counter; the MSB is the taken/not-taken prediction.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_param_if.sv
// Fetch-side lookup and EX-side resolve bundle of the branch predictor.
// master = pipeline driving fetch/resolve, slave = predictor.
interface branch_predictor_param_if #(
  parameter int ADDR_W = 32,
  parameter int GHR_W  = 3
);
  logic              if_valid;
  logic              if_stall;
  logic [ADDR_W-1:0] if_pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              pred_hit;
  logic [GHR_W-1:0]  pred_ghr;
  logic [ADDR_W-1:0] next_pc;

  logic              ex_valid;
  logic              ex_is_branch;
  logic [ADDR_W-1:0] ex_pc;
  logic              ex_taken;
  logic [ADDR_W-1:0] ex_target;
  logic              ex_pred_taken;
  logic [ADDR_W-1:0] ex_pred_tgt;
  logic [GHR_W-1:0]  ex_ghr;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output if_valid, if_stall, if_pc,
    output ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
    output ex_pred_taken, ex_pred_tgt, ex_ghr,
    input  pred_taken, pred_target, pred_hit, pred_ghr, next_pc,
    input  redirect, redirect_pc
  );

  modport slave (
    input  if_valid, if_stall, if_pc,
    input  ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
    input  ex_pred_taken, ex_pred_tgt, ex_ghr,
    output pred_taken, pred_target, pred_hit, pred_ghr, next_pc,
    output redirect, redirect_pc
  );
endinterface

// File: rtl/branch_predictor_param_btb.sv
// Direct-mapped tagged BTB: one combinational read port, one write port.
// Only the valid bits are reset; tag/target are don't-care while invalid.
module bp_btb_array #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 3,
  parameter int TAG_W  = ADDR_W - IDX_W - 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic              rd_hit,
  output logic [ADDR_W-1:0] rd_target,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [ADDR_W-1:0] wr_target
);
  localparam int N = 1 << IDX_W;

  logic [N-1:0]      valid;
  logic [TAG_W-1:0]  tag    [N];
  logic [ADDR_W-1:0] target [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  valid         <= '0;
    else if (we) valid[wr_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag[wr_idx]    <= wr_tag;
      target[wr_idx] <= wr_target;
    end
  end

  // Read is pre-write: a same-cycle update becomes visible next cycle.
  assign rd_hit    = valid[rd_idx] && (tag[rd_idx] == rd_tag);
  assign rd_target = target[rd_idx];

endmodule

// File: rtl/branch_predictor_param.sv
// Dynamic branch predictor: 2-bit counter table + tagged BTB, bimodal or gshare.
// Zero-cycle lookup for IF, combinational redirect and table training from EX.
module branch_predictor_param
  import bp_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int PHT_IDX_W = 3,
  parameter int BTB_IDX_W = 3,
  parameter int GHR_W     = 3,
  parameter int MODE      = MODE_BIMODAL
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_predictor_param_if.slave bp
);
  localparam int PHT_N = 1 << PHT_IDX_W;
  localparam int TAG_W = ADDR_W - BTB_IDX_W - 2;

  logic [1:0]           ctr [PHT_N];
  logic [GHR_W-1:0]     ghr;
  logic [PHT_IDX_W-1:0] rd_pidx, wr_pidx;
  logic                 btb_hit;
  logic [ADDR_W-1:0]    btb_tgt;
  logic                 pred_t;
  logic                 res, mispredict, redir;
  logic [ADDR_W-1:0]    if_pc4, ex_pc4, redir_pc;
  logic                 unused_ex_ghr;

  function automatic logic [PHT_IDX_W-1:0] pht_hash(input logic [PHT_IDX_W-1:0] base,
                                                    input logic [GHR_W-1:0]     hist);
    if (MODE == MODE_GSHARE) return base ^ PHT_IDX_W'(hist);
    return base;
  endfunction

  // Fetch-side lookup
  assign rd_pidx = pht_hash(bp.if_pc[PHT_IDX_W+1:2], ghr);

  bp_btb_array #(.ADDR_W(ADDR_W), .IDX_W(BTB_IDX_W), .TAG_W(TAG_W)) u_btb (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (bp.if_pc[BTB_IDX_W+1:2]),
    .rd_tag    (bp.if_pc[ADDR_W-1:BTB_IDX_W+2]),
    .rd_hit    (btb_hit),
    .rd_target (btb_tgt),
    .we        (res && bp.ex_taken),
    .wr_idx    (bp.ex_pc[BTB_IDX_W+1:2]),
    .wr_tag    (bp.ex_pc[ADDR_W-1:BTB_IDX_W+2]),
    .wr_target (bp.ex_target)
  );

  assign pred_t = btb_hit & ctr[rd_pidx][1];
  assign if_pc4 = bp.if_pc + ADDR_W'(4);
  assign ex_pc4 = bp.ex_pc + ADDR_W'(4);

  // EX-side resolve; a direction match with a stale target still redirects
  assign res        = bp.ex_valid & bp.ex_is_branch;
  assign mispredict = (bp.ex_taken != bp.ex_pred_taken) |
                      (bp.ex_taken & (bp.ex_target != bp.ex_pred_tgt));
  assign redir      = res & mispredict;
  assign redir_pc   = bp.ex_taken ? bp.ex_target : ex_pc4;
  assign wr_pidx    = pht_hash(bp.ex_pc[PHT_IDX_W+1:2], bp.ex_ghr);

  assign bp.pred_taken  = pred_t;
  assign bp.pred_target = btb_tgt;
  assign bp.pred_hit    = btb_hit;
  assign bp.pred_ghr    = ghr;
  assign bp.redirect    = redir;
  assign bp.redirect_pc = redir_pc;
  assign bp.next_pc     = redir ? redir_pc : (pred_t ? btb_tgt : if_pc4);

  // The MSB of ex_ghr only matters for gshare indexing; restore drops it.
  assign unused_ex_ghr = ^bp.ex_ghr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PHT_N; i++) ctr[i] <= CTR_WNT;
    end else if (res) begin
      ctr[wr_pidx] <= ctr_next(ctr[wr_pidx], bp.ex_taken);
    end
  end

  // Restoring from the resolved branch wins over speculative shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ghr <= '0;
    else if (redir)
      ghr <= {bp.ex_ghr[GHR_W-2:0], bp.ex_taken};
    else if (bp.if_valid && !bp.if_stall && btb_hit)
      ghr <= {ghr[GHR_W-2:0], pred_t};
  end

endmodule
